coherence_bus_ctrl: RTL

COHERENCE_BUS_CTRL -- requirements
Module: coherence_bus_ctrl

---
 rtl/coherence_bus_ctrl.sv | 171 +++++++++++++++++
 1 files changed

// File: rtl/coherence_bus_ctrl.sv
// Snooping coherence bus controller: arbitrates L1 coherence requests,
// snoops the other caches, and moves one block by cache-to-cache or memory.
// Ports:
//   CLK, RST                      clock, synchronous active-high reset
//   cctrans/ccwrite/daddr         per-core request, BusRdX intent, block base
//   snoophit/dstore               per-core snoop response and owner data
//   ccwait/ccinv/ccsnoopaddr      per-core snoop control
//   dload/dwait                   per-core fill data and word handshake
//   ramREN/ramWEN/ramaddr/ramstore/ramload/ramready   memory port
//   c2c                           current transfer is cache-to-cache
module coherence_bus_ctrl #(
    parameter int NCORES = 2,
    parameter int WORDS  = 2,
    parameter int AW     = 32,
    parameter int DW     = 32
) (
    input  logic                 CLK,
    input  logic                 RST,
    input  logic [NCORES-1:0]    cctrans,
    input  logic [NCORES-1:0]    ccwrite,
    input  logic [NCORES*AW-1:0] daddr,
    input  logic [NCORES-1:0]    snoophit,
    input  logic [NCORES*DW-1:0] dstore,
    output logic [NCORES-1:0]    ccwait,
    output logic [NCORES-1:0]    ccinv,
    output logic [NCORES*AW-1:0] ccsnoopaddr,
    output logic [NCORES*DW-1:0] dload,
    output logic [NCORES-1:0]    dwait,
    output logic                 ramREN,
    output logic                 ramWEN,
    output logic [AW-1:0]        ramaddr,
    output logic [DW-1:0]        ramstore,
    input  logic [DW-1:0]        ramload,
    input  logic                 ramready,
    output logic                 c2c
);

    localparam int IW = (NCORES > 1) ? $clog2(NCORES) : 1;
    localparam int KW = (WORDS > 1) ? $clog2(WORDS) : 1;

    typedef enum logic [2:0] {
        IDLE,
        SNOOP,
        XFER,
        MEMRD,
        DONE
    } state_t;

    state_t        state;
    state_t        next_state;
    logic [IW-1:0] req;
    logic [IW-1:0] last;
    logic [IW-1:0] owner;
    logic [IW-1:0] grant;
    logic [IW-1:0] hit_idx;
    logic          grant_vld;
    logic          hit_vld;
    logic          wr;
    logic [AW-1:0] base;
    logic [KW-1:0] k;
    logic          last_word;
    logic [AW-1:0] word_addr;

    assign last_word = (k == KW'(WORDS - 1));
    assign word_addr = base + (AW'(k) << 2);

    // Round robin: scan from farthest to nearest after the last-served
    // index so the nearest requester wins.
    always_comb begin
        grant     = '0;
        grant_vld = 1'b0;
        for (int i = NCORES; i >= 1; i--) begin
            if (cctrans[(int'(last) + i) % NCORES]) begin
                grant     = IW'((int'(last) + i) % NCORES);
                grant_vld = 1'b1;
            end
        end
    end

    // Lowest-index hitting non-requester owns the block.
    always_comb begin
        hit_idx = '0;
        hit_vld = 1'b0;
        for (int i = NCORES - 1; i >= 0; i--) begin
            if (snoophit[i] && (IW'(i) != req)) begin
                hit_idx = IW'(i);
                hit_vld = 1'b1;
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state <= IDLE;
            last  <= IW'(NCORES - 1);
            k     <= '0;
            req   <= '0;
            owner <= '0;
            wr    <= 1'b0;
            base  <= '0;
        end else begin
            state <= next_state;
            case (state)
                IDLE: begin
                    if (grant_vld) begin
                        req  <= grant;
                        wr   <= ccwrite[grant];
                        base <= daddr[grant*AW +: AW];
                        k    <= '0;
                    end
                end
                SNOOP: owner <= hit_idx;
                XFER, MEMRD: begin
                    if (ramready) k <= k + KW'(1);
                end
                DONE: last <= req;
                default: ;
            endcase
        end
    end

    always_comb begin
        next_state  = state;
        ccwait      = '0;
        ccinv       = '0;
        ccsnoopaddr = '0;
        dload       = '0;
        dwait       = '1;
        ramREN      = 1'b0;
        ramWEN      = 1'b0;
        ramaddr     = '0;
        ramstore    = '0;
        c2c         = 1'b0;
        unique case (state)
            IDLE: begin
                if (grant_vld) next_state = SNOOP;
            end
            SNOOP: begin
                for (int i = 0; i < NCORES; i++) begin
                    if (IW'(i) != req) begin
                        ccwait[i]                = 1'b1;
                        ccinv[i]                 = wr;
                        ccsnoopaddr[i*AW +: AW]  = base;
                    end
                end
                next_state = hit_vld ? XFER : MEMRD;
            end
            XFER: begin
                c2c                         = 1'b1;
                ccwait[owner]               = 1'b1;
                ccsnoopaddr[owner*AW +: AW] = word_addr;
                ramWEN                      = 1'b1;
                ramaddr                     = word_addr;
                ramstore                    = dstore[owner*DW +: DW];
                dload[req*DW +: DW]         = dstore[owner*DW +: DW];
                dwait[req]                  = !ramready;
                if (ramready && last_word) next_state = DONE;
            end
            MEMRD: begin
                ramREN              = 1'b1;
                ramaddr             = word_addr;
                dload[req*DW +: DW] = ramload;
                dwait[req]          = !ramready;
                if (ramready && last_word) next_state = DONE;
            end
            DONE: next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

endmodule
